// File: rtl/x1_cond_pkg.sv
// rtl/x1_cond_pkg.sv - shared state encoding and widths for the x1 input conditioner
package x1_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        QUAL_HIGH   = 2'b01,
        QUAL_LOW    = 2'b10,
        STABLE_HIGH = 2'b11
    } state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/x1_conditioner_sync_chain.sv
// rtl/x1_conditioner_sync_chain.sv - plain flop chain synchronizer for an asynchronous pin
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    // Pure shift register: nothing may sit between stages or metastability escapes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/x1_conditioner.sv
// rtl/x1_conditioner.sv - synchronize and debounce raw x1 pin; X1_COND_GLITCH_CNT_EN adds glitch_cnt
module x1_conditioner
    import x1_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic x1,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef X1_COND_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             x1_nxt, rise_nxt, fall_nxt;
    logic             glitch_abort;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (raw_in),
        .q    (s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            x1    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x1    <= x1_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // The entering sample counts as the first qualified cycle, hence cnt<=1 on entry.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        x1_nxt       = x1;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        glitch_abort = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (s) begin
                    state_nxt = QUAL_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            QUAL_HIGH: begin
                if (!s) begin
                    state_nxt    = STABLE_LOW;
                    cnt_nxt      = '0;
                    glitch_abort = 1'b1;
                end else if (cnt == DB_LAST) begin
                    state_nxt = STABLE_HIGH;
                    x1_nxt    = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_nxt = QUAL_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            QUAL_LOW: begin
                if (s) begin
                    state_nxt    = STABLE_HIGH;
                    cnt_nxt      = '0;
                    glitch_abort = 1'b1;
                end else if (cnt == DB_LAST) begin
                    state_nxt = STABLE_LOW;
                    x1_nxt    = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                x1_nxt    = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == QUAL_HIGH) || (state == QUAL_LOW);

`ifdef X1_COND_GLITCH_CNT_EN
    // Saturating count of rejected qualifications; reset takes priority over an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (glitch_abort && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end
`else
    logic unused_glitch_abort;
    assign unused_glitch_abort = glitch_abort;
`endif

endmodule

// File: tb/tb_x1_conditioner.sv
// tb/tb_x1_conditioner.sv - randomized and directed check of x1_conditioner against a run-length model
module tb_x1_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_in = 1'b0;
    logic x1_0, rise_0, fall_0, busy_0;
    logic x1_1, rise_1, fall_1, busy_1;
`ifdef X1_COND_GLITCH_CNT_EN
    logic [7:0] gc_0, gc_1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    x1_conditioner dut0 (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .x1(x1_0), .rise(rise_0), .fall(fall_0), .busy(busy_0)
`ifdef X1_COND_GLITCH_CNT_EN
        , .glitch_cnt(gc_0)
`endif
    );

    x1_conditioner #(.SYNC_STAGES(3), .DB_CYCLES(2), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .x1(x1_1), .rise(rise_1), .fall(fall_1), .busy(busy_1)
`ifdef X1_COND_GLITCH_CNT_EN
        , .glitch_cnt(gc_1)
`endif
    );

    // Model: raw history plus, per instance, the length of the current run of
    // synchronized samples that disagree with the debounced level.
    bit hist[$];
    bit m_x1[2];
    bit m_rise[2];
    bit m_fall[2];
    int m_run[2];
    int m_gl[2];

    function automatic int stg(int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic int dbc(int m);
        return (m == 0) ? 4 : 2;
    endfunction

    task automatic model_edge(input bit r, input bit rst);
        bit s;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 4; i++) hist.push_back(1'b0);
            for (int m = 0; m < 2; m++) begin
                m_x1[m] = 0; m_rise[m] = 0; m_fall[m] = 0; m_run[m] = 0; m_gl[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                s = hist[hist.size() - stg(m)];
                m_rise[m] = 0;
                m_fall[m] = 0;
                if (s != m_x1[m]) begin
                    m_run[m]++;
                    if (m_run[m] == dbc(m)) begin
                        m_x1[m] = s;
                        m_rise[m] = s;
                        m_fall[m] = !s;
                        m_run[m] = 0;
                    end
                end else begin
                    if (m_run[m] > 0 && m_gl[m] < 255) m_gl[m]++;
                    m_run[m] = 0;
                end
            end
            hist.push_back(r);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rst);
        raw_in = r;
        reset = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
        chk("x1_0", x1_0, m_x1[0]);
        chk("rise_0", rise_0, m_rise[0]);
        chk("fall_0", fall_0, m_fall[0]);
        chk("busy_0", busy_0, m_run[0] > 0);
        chk("x1_1", x1_1, m_x1[1]);
        chk("rise_1", rise_1, m_rise[1]);
        chk("fall_1", fall_1, m_fall[1]);
        chk("busy_1", busy_1, m_run[1] > 0);
        chk("no_rise_fall_0", rise_0 & fall_0, 1'b0);
`ifdef X1_COND_GLITCH_CNT_EN
        chk8("glitch_cnt_0", gc_0, 8'(m_gl[0]));
        chk8("glitch_cnt_1", gc_1, 8'(m_gl[1]));
`endif
    endtask

    initial begin
        bit lvl;
        int len;
        int rises;
        bit bounce[9];

        // Reset, then a clean rising step with fixed latencies.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0);
            chk("lat_x1_0", x1_0, e >= 5);
            chk("lat_rise_0", rise_0, e == 5);
            chk("lat_busy_0", busy_0, e >= 2 && e <= 4);
            chk("lat_x1_1", x1_1, e >= 4);
        end

        // Falling step.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b0);
            chk("fall_lat_x1_0", x1_0, e < 5);
            chk("fall_pulse_0", fall_0, e == 5);
        end

        // Two-cycle glitch is rejected by the DB=4 instance.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int e = 0; e < 6; e++) step(1'b0, 1'b0);
        chk("glitch_x1_0", x1_0, 1'b0);
        chk("glitch_busy_0", busy_0, 1'b0);

        // Bounce burst, then held high: exactly one rise.
        bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        rises = 0;
        for (int i = 0; i < 9; i++) begin
            step(bounce[i], 1'b0);
            if (rise_0) rises++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (rise_0) rises++;
        end
        chk("bounce_rise_once", rises == 1, 1'b1);
        chk("bounce_x1_0", x1_0, 1'b1);

        // Back low, then reset in the middle of a high qualification.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("pre_reset_busy_0", busy_0, 1'b1);
        step(1'b1, 1'b1);
        chk("mid_reset_busy_0", busy_0, 1'b0);
        chk("mid_reset_x1_0", x1_0, 1'b0);
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0);
            chk("relat_x1_0", x1_0, e >= 5);
        end

        // Reset while x1=1: drop with no fall pulse.
        step(1'b1, 1'b1);
        chk("reset_high_fall_0", fall_0, 1'b0);

        // Randomized runs of random length.
        lvl = 0;
        for (int i = 0; i < 400; i++) begin
            len = $urandom_range(1, 8);
            lvl = ~lvl;
            for (int k = 0; k < len; k++) step(lvl, ($urandom_range(0, 199) == 0));
        end

        // Many single-cycle glitches, enough to saturate the optional counter.
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("sat_x1_0", x1_0, 1'b0);
`ifdef X1_COND_GLITCH_CNT_EN
        chk8("sat_glitch_cnt_0", gc_0, 8'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
